// File: rtl/tiny16_pkg.sv
// Shared encodings for the tiny16 control path: instruction fields, opcodes, ALU ops,
// regfile input-mux codes, sequencer states and decoded operation classes.
package tiny16_pkg;

    localparam int unsigned OpMsb  = 15;
    localparam int unsigned OpLsb  = 12;
    localparam int unsigned DstMsb = 11;
    localparam int unsigned DstLsb = 9;
    localparam int unsigned SrcMsb = 8;
    localparam int unsigned SrcLsb = 6;
    localparam int unsigned ImmMsb = 7;

    localparam logic [3:0] OpNop   = 4'h0;
    localparam logic [3:0] OpMov   = 4'h1;
    localparam logic [3:0] OpAdd   = 4'h2;
    localparam logic [3:0] OpSub   = 4'h3;
    localparam logic [3:0] OpAnd   = 4'h4;
    localparam logic [3:0] OpOr    = 4'h5;
    localparam logic [3:0] OpXor   = 4'h6;
    localparam logic [3:0] OpLdi   = 4'h7;
    localparam logic [3:0] OpLd    = 4'h8;
    localparam logic [3:0] OpSt    = 4'h9;
    localparam logic [3:0] OpJmp   = 4'hA;
    localparam logic [3:0] OpJz    = 4'hB;
    localparam logic [3:0] OpIllLo = 4'hC;
    localparam logic [3:0] OpIllHi = 4'hE;
    localparam logic [3:0] OpHlt   = 4'hF;

    typedef enum logic [2:0] {
        AluPass = 3'd0, AluAdd = 3'd1, AluSub = 3'd2, AluAnd = 3'd3, AluOr = 3'd4, AluXor = 3'd5
    } alu_op_e;

    typedef enum logic [1:0] {InSelAlu = 2'd0, InSelMem = 2'd1, InSelImm = 2'd2} in_sel_e;

    typedef enum logic [2:0] {StFetch, StMemRd, StDecode, StExec, StMem, StHalt} state_e;

    typedef enum logic [2:0] {
        ClsNop, ClsAlu, ClsLdi, ClsLd, ClsSt, ClsJmp, ClsJz, ClsHlt
    } op_class_e;

    function automatic logic is_illegal(input logic [3:0] op);
        return (op >= OpIllLo) && (op <= OpIllHi);
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: splits ir into operand fields, zero-extended imm8,
// an operation class and ALU op. Illegal opcodes decode as NOP with o_illegal raised.
module instr_decoder
    import tiny16_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_ir,
    output op_class_e        o_class,
    output logic [2:0]       o_dst,
    output logic [2:0]       o_src,
    output logic [WIDTH-1:0] o_imm,
    output alu_op_e          o_alu_op,
    output logic             o_illegal
);

    logic [3:0] w_op;

    assign w_op      = i_ir[OpMsb:OpLsb];
    assign o_dst     = i_ir[DstMsb:DstLsb];
    assign o_src     = i_ir[SrcMsb:SrcLsb];
    assign o_imm     = {{(WIDTH-8){1'b0}}, i_ir[ImmMsb:0]};
    assign o_illegal = is_illegal(w_op);

    always_comb begin
        o_class  = ClsNop;
        o_alu_op = AluPass;
        unique case (w_op)
            OpMov: o_class = ClsAlu;
            OpAdd: begin o_class = ClsAlu; o_alu_op = AluAdd; end
            OpSub: begin o_class = ClsAlu; o_alu_op = AluSub; end
            OpAnd: begin o_class = ClsAlu; o_alu_op = AluAnd; end
            OpOr:  begin o_class = ClsAlu; o_alu_op = AluOr;  end
            OpXor: begin o_class = ClsAlu; o_alu_op = AluXor; end
            OpLdi: o_class = ClsLdi;
            OpLd:  o_class = ClsLd;
            OpSt:  o_class = ClsSt;
            OpJmp: o_class = ClsJmp;
            OpJz:  o_class = ClsJz;
            OpHlt: o_class = ClsHlt;
            default: o_class = ClsNop;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// tiny16 multi-cycle fetch/decode/execute sequencer driving the regfile, ALU op and memory handshake.
// Define CTRL_TRAP_EN to halt on illegal opcodes and expose the sticky trap output.
module control_unit
    import tiny16_pkg::*;
#(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] instr,
    input  logic             mem_ready,
    input  logic             zero_flag,
    output logic [2:0]       src_sel,
    output logic [2:0]       dst_sel,
    output logic             in_en,
    output logic             out_en,
    output logic             pc_inc,
    output logic [1:0]       in_sel,
    output logic [WIDTH-1:0] imm,
    output logic [2:0]       alu_op,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             halted,
`ifdef CTRL_TRAP_EN
    output logic             trap,
`endif
    output logic             bus_err
);

    localparam int unsigned WaitW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'((MEM_WAIT_MAX == 0) ? 0 : MEM_WAIT_MAX - 1);
`ifdef CTRL_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    state_e           r_state, w_state_next;
    logic [WIDTH-1:0] r_ir;
    logic [WaitW-1:0] r_wait_cnt, w_wait_cnt_next;
    logic             r_bus_err, w_bus_err_set;
    logic             r_rst_seen;
    logic             w_ir_load, w_hold;

    op_class_e        w_class;
    logic [2:0]       w_dst, w_src;
    logic [WIDTH-1:0] w_imm;
    alu_op_e          w_alu_op;
    logic             w_illegal;

    instr_decoder #(.WIDTH(WIDTH)) u_decoder (
        .i_ir      (r_ir),
        .o_class   (w_class),
        .o_dst     (w_dst),
        .o_src     (w_src),
        .o_imm     (w_imm),
        .o_alu_op  (w_alu_op),
        .o_illegal (w_illegal)
    );

    // r_rst_seen keeps outputs quiet and parks in FETCH for as long as rst is sampled high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StFetch;
            r_ir       <= '0;
            r_wait_cnt <= '0;
            r_bus_err  <= 1'b0;
            r_rst_seen <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            r_rst_seen <= 1'b0;
            if (w_ir_load)     r_ir      <= instr;
            if (w_bus_err_set) r_bus_err <= 1'b1;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = '0;
        w_bus_err_set   = 1'b0;
        w_ir_load       = 1'b0;
        w_hold          = 1'b0;
        src_sel         = 3'd0;
        dst_sel         = 3'd0;
        in_en           = 1'b0;
        out_en          = 1'b0;
        pc_inc          = 1'b0;
        in_sel          = InSelAlu;
        alu_op          = AluPass;
        mem_rd          = 1'b0;
        mem_wr          = 1'b0;
        halted          = 1'b0;
        if (r_rst_seen) begin
            w_state_next = StFetch;
        end else begin
            unique case (r_state)
                StFetch: begin
                    out_en       = 1'b1;
                    w_state_next = StMemRd;
                end
                StMemRd: begin
                    out_en = 1'b1;
                    mem_rd = 1'b1;
                    if (mem_ready) begin
                        w_ir_load    = 1'b1;
                        pc_inc       = 1'b1;
                        w_state_next = StDecode;
                    end else begin
                        w_hold = 1'b1;
                    end
                end
                StDecode: begin
                    src_sel      = w_src;
                    dst_sel      = w_dst;
                    w_state_next = StExec;
                end
                StExec: begin
                    src_sel      = w_src;
                    dst_sel      = w_dst;
                    alu_op       = w_alu_op;
                    w_state_next = StFetch;
                    unique case (w_class)
                        ClsAlu: in_en = 1'b1;
                        ClsLdi: begin in_en = 1'b1; in_sel = InSelImm; end
                        ClsJmp: begin dst_sel = 3'd0; alu_op = AluPass; in_en = 1'b1; end
                        ClsJz:  begin dst_sel = 3'd0; alu_op = AluPass; in_en = zero_flag; end
                        ClsLd, ClsSt: begin out_en = 1'b1; w_state_next = StMem; end
                        ClsHlt: w_state_next = StHalt;
                        ClsNop: if (TrapEn && w_illegal) w_state_next = StHalt;
                        default: w_state_next = StFetch;
                    endcase
                end
                StMem: begin
                    src_sel = w_src;
                    dst_sel = w_dst;
                    if (w_class == ClsSt) mem_wr = 1'b1;
                    else                  mem_rd = 1'b1;
                    if (mem_ready) begin
                        if (w_class != ClsSt) begin
                            in_en  = 1'b1;
                            in_sel = InSelMem;
                        end
                        w_state_next = StFetch;
                    end else begin
                        w_hold = 1'b1;
                    end
                end
                StHalt: halted = 1'b1;
                default: w_state_next = StFetch;
            endcase
            if (w_hold) begin
                if ((MEM_WAIT_MAX != 0) && (r_wait_cnt == WaitLast)) begin
                    w_state_next  = StHalt;
                    w_bus_err_set = 1'b1;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 1'b1;
                end
            end
        end
    end

    assign imm     = w_imm;
    assign bus_err = r_bus_err;

`ifdef CTRL_TRAP_EN
    logic r_trap;
    always_ff @(posedge clk) begin
        if (rst)                                  r_trap <= 1'b0;
        else if ((r_state == StExec) && w_illegal) r_trap <= 1'b1;
    end
    assign trap = r_trap;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus random instruction streams,
// each compared cycle by cycle against an expected-output transcript built per instruction.
module tb_control_unit;

    localparam int unsigned MaxWait = 15;

    localparam int PImm = 0, PDst = 16, PSrc = 19, PAlu = 22, PInSel = 25;
    localparam int POutEn = 27, PInEn = 28, PPcInc = 29, PMemRd = 30, PMemWr = 31;
    localparam int PBusErr = 32, PHalt = 33;
    localparam logic [33:0] StrobeMask = 34'h3_F800_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = '0;
    logic        mem_ready = 1'b0;
    logic        zero_flag = 1'b0;
    logic [2:0]  src_sel, dst_sel, alu_op;
    logic        in_en, out_en, pc_inc, mem_rd, mem_wr, halted, bus_err;
    logic [1:0]  in_sel;
    logic [15:0] imm;
`ifdef CTRL_TRAP_EN
    logic        trap;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [33:0] v;
        logic [33:0] m;
        logic [15:0] instr;
        logic        ready;
        logic        zf;
        logic [63:0] tag;
        logic [15:0] word;
    } cyc_t;

    cyc_t exp_q[$];

    control_unit #(.WIDTH(16), .MEM_WAIT_MAX(MaxWait)) dut (
        .clk       (clk),
        .rst       (rst),
        .instr     (instr),
        .mem_ready (mem_ready),
        .zero_flag (zero_flag),
        .src_sel   (src_sel),
        .dst_sel   (dst_sel),
        .in_en     (in_en),
        .out_en    (out_en),
        .pc_inc    (pc_inc),
        .in_sel    (in_sel),
        .imm       (imm),
        .alu_op    (alu_op),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .halted    (halted),
`ifdef CTRL_TRAP_EN
        .trap      (trap),
`endif
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    function automatic logic [33:0] outs();
        return {halted, bus_err, mem_wr, mem_rd, pc_inc, in_en, out_en, in_sel, alu_op,
                src_sel, dst_sel, imm};
    endfunction

    // Every cycle cares about all strobes; data fields are cared only where the spec pins them.
    function automatic cyc_t mk(input logic [63:0] tag, input logic [15:0] w);
        cyc_t c;
        c.v     = '0;
        c.m     = StrobeMask;
        c.instr = 16'($urandom);
        c.ready = 1'($urandom_range(0, 1));
        c.zf    = 1'($urandom_range(0, 1));
        c.tag   = tag;
        c.word  = w;
        return c;
    endfunction

    function automatic cyc_t fld(input cyc_t c, input int lsb, input int w, input logic [15:0] val);
        cyc_t r = c;
        for (int i = 0; i < w; i++) begin
            r.v[lsb+i] = val[i];
            r.m[lsb+i] = 1'b1;
        end
        return r;
    endfunction

    task automatic push_halt(input int n, input logic be);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = mk("halt", 16'h0);
            c.v[PHalt]   = 1'b1;
            c.v[PBusErr] = be;
            exp_q.push_back(c);
        end
    endtask

    task automatic push_fetch(input logic [15:0] w, input int fw);
        cyc_t c;
        c = fld(mk("fetch", w), PSrc, 3, 16'd0);
        c.v[POutEn] = 1'b1;
        exp_q.push_back(c);
        for (int i = 0; i < fw; i++) begin
            c = fld(mk("memrdw", w), PSrc, 3, 16'd0);
            c.ready = 1'b0;
            c.v[POutEn] = 1'b1;
            c.v[PMemRd] = 1'b1;
            exp_q.push_back(c);
        end
    endtask

    // Expected transcript of one instruction from FETCH back to the next FETCH (or HALT).
    task automatic model_instr(input logic [15:0] w, input int fw, input int mw, input logic zf);
        cyc_t c;
        logic [3:0] op;
        logic [2:0] d, s;
        op = w[15:12];
        d  = w[11:9];
        s  = w[8:6];
        push_fetch(w, fw);
        c = fld(mk("memrd", w), PSrc, 3, 16'd0);
        c.ready = 1'b1;
        c.instr = w;
        c.v[POutEn] = 1'b1;
        c.v[PMemRd] = 1'b1;
        c.v[PPcInc] = 1'b1;
        exp_q.push_back(c);
        c = fld(fld(mk("decode", w), PSrc, 3, 16'(s)), PDst, 3, 16'(d));
        exp_q.push_back(c);
        c = mk("exec", w);
        c.zf = zf;
        if (op >= 4'd1 && op <= 4'd6) begin
            c = fld(fld(fld(c, PSrc, 3, 16'(s)), PDst, 3, 16'(d)), PInSel, 2, 16'd0);
            c = fld(c, PAlu, 3, (op == 4'd1) ? 16'd0 : 16'(op - 4'd1));
            c.v[PInEn] = 1'b1;
        end else if (op == 4'd7) begin
            c = fld(fld(fld(c, PDst, 3, 16'(d)), PInSel, 2, 16'd2), PImm, 16, {8'h00, w[7:0]});
            c.v[PInEn] = 1'b1;
        end else if (op == 4'd8 || op == 4'd9) begin
            c = fld(c, PSrc, 3, 16'(s));
            c.v[POutEn] = 1'b1;
        end else if (op == 4'hA || (op == 4'hB && zf)) begin
            c = fld(fld(fld(c, PSrc, 3, 16'(s)), PDst, 3, 16'd0), PAlu, 3, 16'd0);
            c.v[PInEn] = 1'b1;
        end
        exp_q.push_back(c);
        if (op == 4'd8 || op == 4'd9) begin
            for (int i = 0; i <= mw; i++) begin
                c = fld(mk((i == mw) ? "memdone" : "memwait", w), PDst, 3, 16'(d));
                c.ready = (i == mw);
                if (op == 4'd8) c.v[PMemRd] = 1'b1;
                else            c.v[PMemWr] = 1'b1;
                if (op == 4'd8 && i == mw) begin
                    c = fld(c, PInSel, 2, 16'd1);
                    c.v[PInEn] = 1'b1;
                end
                exp_q.push_back(c);
            end
        end
    endtask

    task automatic play();
        cyc_t e;
        logic [33:0] got;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            instr     = e.instr;
            mem_ready = e.ready;
            zero_flag = e.zf;
            #1;
            got = outs();
            n_checks++;
            if ((got & e.m) !== (e.v & e.m)) begin
                n_errors++;
                $display("FAIL %0s word=%h: got %h expected %h (mask %h)", e.tag, e.word,
                         got & e.m, e.v & e.m, e.m);
            end
        end
    endtask

    task automatic apply_reset(input bit mid_memrd);
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b0;
        #1;
        if (mid_memrd) begin
            n_checks++;
            if (mem_rd !== 1'b1) begin
                n_errors++;
                $display("FAIL reset_pre_edge_mem_rd: got %b expected 1", mem_rd);
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if (outs() !== 34'h0 || bus_err !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_outputs_zero: got %h expected 0", outs());
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(1'b0);
    endtask

    task automatic test_ldi_alu();
        model_instr(16'h765A, 0, 0, 1'b0);
        model_instr(16'h2440, 0, 0, 1'b1);
        play();
    endtask

    task automatic test_ld_wait();
        model_instr(16'h8940, 0, 3, 1'b0);
        model_instr(16'h9A80, 2, 1, 1'b0);
        play();
    endtask

    task automatic test_jz();
        model_instr(16'hB180, 0, 0, 1'b0);
        model_instr(16'hB180, 1, 0, 1'b1);
        play();
    endtask

    task automatic test_reset_mid_memrd();
        push_fetch(16'h0, 2);
        play();
        apply_reset(1'b1);
        model_instr(16'h1A40, 0, 0, 1'b0);
        play();
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [15:0] w;
        for (int n = 0; n < 40; n++) begin
            do begin
                op = 4'($urandom_range(0, 14));
            end while (op == 4'hF && 1'b1 || (op >= 4'hC && op <= 4'hE && TrapBuild()));
            w = {op, 12'($urandom)};
            model_instr(w, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                        1'($urandom_range(0, 1)));
        end
        play();
    endtask

    function automatic bit TrapBuild();
`ifdef CTRL_TRAP_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic test_illegal();
`ifdef CTRL_TRAP_EN
        model_instr(16'hC000, 0, 0, 1'b0);
        push_halt(3, 1'b0);
        play();
        n_checks++;
        if (trap !== 1'b1) begin
            n_errors++;
            $display("FAIL trap_set: got %b expected 1", trap);
        end
        apply_reset(1'b0);
        n_checks++;
        if (trap !== 1'b0) begin
            n_errors++;
            $display("FAIL trap_cleared: got %b expected 0", trap);
        end
`else
        model_instr(16'hC000, 0, 0, 1'b0);
        model_instr(16'h7E11, 0, 0, 1'b0);
        play();
`endif
    endtask

    task automatic test_hlt();
        model_instr(16'hF000, 1, 0, 1'b0);
        push_halt(4, 1'b0);
        play();
        apply_reset(1'b0);
    endtask

    task automatic test_timeout();
        push_fetch(16'h0, int'(MaxWait));
        push_halt(4, 1'b1);
        play();
        apply_reset(1'b0);
        model_instr(16'h3000, 0, 0, 1'b0);
        play();
    endtask

    initial begin
        test_reset();
        test_ldi_alu();
        test_ld_wait();
        test_jz();
        test_reset_mid_memrd();
        test_random();
        test_illegal();
        test_hlt();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
